// File: rtl/alu_job_sequencer.sv
// ALU job sequencer: buffers jobs in a small FIFO, runs them one at a time on an
// external nibble loop, and returns each result (or a timeout error) over valid/ready.
package alu_job_pkg;
    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        LSHFT = 3'd5,
        RSHFT = 3'd6,
        PASS  = 3'd7
    } AluCmd;
endpackage

module alu_job_sequencer
    import alu_job_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  AluCmd       req_cmd,
    input  logic [31:0] req_word1,
    input  logic [31:0] req_word2,
    output logic        loop_start,
    output logic        loop_reverse,
    output AluCmd       loop_cmd,
    output logic        loop_clear_carry,
    output logic [31:0] loop_word1,
    output logic [31:0] loop_word2,
    input  logic        loop_busy,
    input  logic [31:0] loop_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_RISE = 3'd2,
        RUN       = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    AluCmd         fifo_cmd   [FIFO_DEPTH];
    logic [31:0]   fifo_word1 [FIFO_DEPTH];
    logic [31:0]   fifo_word2 [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    AluCmd         job_cmd;
    logic [31:0]   job_word1;
    logic [31:0]   job_word2;
    logic [CW-1:0] tmo_cnt;
    logic          in_busy_wait;
    logic          tmo_hit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready;

    // A response handshake pops the next job directly so back-to-back jobs skip IDLE.
    assign pop = !fifo_empty && ((state == IDLE) || (state == RESP && rsp_ready));

    assign in_busy_wait = (state == WAIT_RISE) || (state == RUN);
    assign tmo_hit      = in_busy_wait && (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr[AW-1:0]]   <= req_cmd;
            fifo_word1[wr_ptr[AW-1:0]] <= req_word1;
            fifo_word2[wr_ptr[AW-1:0]] <= req_word2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (tmo_hit) begin
                    state_nxt = RESP;
                end else if (loop_busy) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!loop_busy || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = fifo_empty ? IDLE : LAUNCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        loop_start       = 1'b0;
        loop_clear_carry = 1'b0;
        rsp_valid        = 1'b0;
        case (state)
            LAUNCH: begin
                loop_start       = 1'b1;
                loop_clear_carry = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Job registers load only on pop, so loop operands hold for the whole job.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_cmd    <= ADD;
            job_word1  <= '0;
            job_word2  <= '0;
            tmo_cnt    <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (pop) begin
                job_cmd   <= fifo_cmd[rd_ptr[AW-1:0]];
                job_word1 <= fifo_word1[rd_ptr[AW-1:0]];
                job_word2 <= fifo_word2[rd_ptr[AW-1:0]];
                tmo_cnt   <= '0;
            end else if (in_busy_wait) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // A loop that finishes on the last allowed cycle still counts as a success.
            if (state == RUN && !loop_busy) begin
                rsp_result <= loop_result;
                rsp_error  <= 1'b0;
            end else if (tmo_hit) begin
                rsp_result <= '0;
                rsp_error  <= 1'b1;
            end
        end
    end

    assign loop_cmd     = job_cmd;
    assign loop_word1   = job_word1;
    assign loop_word2   = job_word2;
    assign loop_reverse = (job_cmd == RSHFT);

endmodule

// File: tb/tb_alu_job_sequencer.sv
// Bench for alu_job_sequencer: behavioural nibble-loop model plus a queue-based
// scoreboard of issued jobs; directed scenarios followed by randomized jobs.
module tb_alu_job_sequencer;
    import alu_job_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    AluCmd       req_cmd = ADD;
    logic [31:0] req_word1 = '0;
    logic [31:0] req_word2 = '0;
    logic        loop_start;
    logic        loop_reverse;
    AluCmd       loop_cmd;
    logic        loop_clear_carry;
    logic [31:0] loop_word1;
    logic [31:0] loop_word2;
    logic        loop_busy = 1'b0;
    logic [31:0] loop_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_error;

    alu_job_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_word1(req_word1), .req_word2(req_word2),
        .loop_start(loop_start), .loop_reverse(loop_reverse), .loop_cmd(loop_cmd),
        .loop_clear_carry(loop_clear_carry), .loop_word1(loop_word1), .loop_word2(loop_word2),
        .loop_busy(loop_busy), .loop_result(loop_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        AluCmd       cmd;
        logic [31:0] w1;
        logic [31:0] w2;
    } job_t;

    job_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(AluCmd c, logic [31:0] a, logic [31:0] b);
        case (c)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            LSHFT:   return b << 1;
            RSHFT:   return b >> 1;
            default: return a;
        endcase
    endfunction

    // Nibble-loop model. lm_mode: 0 = busy for lm_len cycles, 1 = busy forever, 2 = never busy.
    int          lm_mode = 0;
    int          lm_len  = 3;
    int          lm_left = 0;
    AluCmd       lm_cmd  = ADD;
    logic [31:0] lm_w1   = '0;
    logic [31:0] lm_w2   = '0;
    int          start_cnt   = 0;
    int          start_cyc   = 0;
    logic        hold_bad    = 1'b0;
    logic        pulse_bad   = 1'b0;
    logic        prev_start  = 1'b0;

    always @(posedge clk) begin
        prev_start <= loop_start;
        if ((loop_start && prev_start) || (loop_start !== loop_clear_carry)) pulse_bad <= 1'b1;
        if (loop_start === 1'b1) begin
            start_cnt   <= start_cnt + 1;
            start_cyc   <= cyc;
            lm_cmd      <= loop_cmd;
            lm_w1       <= loop_word1;
            lm_w2       <= loop_word2;
            hold_bad    <= 1'b0;
            lm_left     <= lm_len;
            loop_busy   <= (lm_mode != 2);
            loop_result <= 32'hDEAD_BEEF;
        end else begin
            if (loop_busy && (loop_cmd !== lm_cmd || loop_word1 !== lm_w1 || loop_word2 !== lm_w2
                              || loop_reverse !== (lm_cmd == RSHFT)))
                hold_bad <= 1'b1;
            if (loop_busy && lm_mode == 0) begin
                if (lm_left <= 1) begin
                    loop_busy   <= 1'b0;
                    loop_result <= alu_ref(lm_cmd, lm_w1, lm_w2);
                end else begin
                    lm_left <= lm_left - 1;
                end
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(AluCmd c, logic [31:0] a, logic [31:0] b);
        int n = 0;
        job_t j;
        req_valid = 1'b1; req_cmd = c; req_word1 = a; req_word2 = b;
        while (req_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) chk("push_ready_tmo", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        j.cmd = c; j.w1 = a; j.w2 = b;
        exp_q.push_back(j);
    endtask

    task automatic wait_valid(string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) chk({tag, "_valid_tmo"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic check_head(string tag, bit exp_err);
        job_t j;
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        j = exp_q.pop_front();
        exp = exp_err ? 32'd0 : alu_ref(j.cmd, j.w1, j.w2);
        chk({tag, "_res"}, rsp_result, exp);
        chk({tag, "_err"}, {31'd0, rsp_error}, {31'd0, exp_err});
        chk({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic take_rsp(string tag, bit exp_err, int stall);
        wait_valid(tag);
        repeat (stall) begin @(posedge clk); #1; end
        chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        check_head(tag, exp_err);
        handshake();
        chk({tag, "_vld_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int s0, c1, c2, n;
        bit saw;
        AluCmd rc;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_loop_start", {31'd0, loop_start}, 32'd0);
        chk("rst_clear_carry", {31'd0, loop_clear_carry}, 32'd0);
        chk("rst_reverse", {31'd0, loop_reverse}, 32'd0);
        chk("rst_word1", loop_word1, 32'd0);
        chk("rst_word2", loop_word2, 32'd0);
        chk("rst_cmd", {29'd0, loop_cmd}, {29'd0, ADD});
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD carry ripple into upper nibble
        lm_mode = 0; lm_len = 3;
        s0 = start_cnt;
        push(ADD, 32'hEFFF_FFFF, 32'h0000_0001);
        wait_valid("add");
        chk("add_result_lit", rsp_result, 32'hF000_0000);
        chk("add_starts", start_cnt - s0, 32'd1);
        take_rsp("add", 1'b0, 2);

        // RSHFT drives loop_reverse
        push(RSHFT, 32'h0, 32'h0600_0000);
        n = 0;
        while (loop_busy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rshft_reverse", {31'd0, loop_reverse}, 32'd1);
        wait_valid("rshft");
        chk("rshft_result_lit", rsp_result, 32'h0300_0000);
        take_rsp("rshft", 1'b0, 0);

        // Throughput with rsp_ready held high: len + 3 cycles per job
        lm_len = 4;
        rsp_ready = 1'b1;
        push(XOR, $urandom, $urandom);
        push(SUB, $urandom, $urandom);
        wait_valid("tp_a");
        c1 = cyc;
        check_head("tp_a", 1'b0);
        @(posedge clk); #1;
        wait_valid("tp_b");
        c2 = cyc;
        check_head("tp_b", 1'b0);
        chk("tp_period", c2 - c1, lm_len + 3);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Backpressure: FIFO fills while the first response is stalled
        lm_len = 2;
        push(ADD, $urandom, $urandom);
        push(OR, $urandom, $urandom);
        push(AND, $urandom, $urandom);
        chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1; req_cmd = LSHFT; req_word1 = 32'h1234_5678; req_word2 = 32'h8765_4321;
        wait_valid("bp_j1");
        chk("bp_held_ready", {31'd0, req_ready}, 32'd0);
        check_head("bp_j1", 1'b0);
        handshake();
        chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
        push(LSHFT, 32'h1234_5678, 32'h8765_4321);
        take_rsp("bp_j2", 1'b0, 1);
        take_rsp("bp_j3", 1'b0, 0);
        take_rsp("bp_j4", 1'b0, 0);

        // Loop stuck busy: timeout TIMEOUT cycles after the LAUNCH cycle
        lm_mode = 1;
        push(ADD, 32'h1111_1111, 32'h2222_2222);
        wait_valid("stuck");
        chk("stuck_latency", cyc - start_cyc, TIMEOUT + 1);
        take_rsp("stuck", 1'b1, 0);

        // Loop never busy: timeout, then the queued job runs normally
        lm_mode = 2;
        push(SUB, 32'h0000_0010, 32'h0000_0001);
        push(ADD, 32'h0000_0010, 32'h0000_0001);
        wait_valid("never");
        lm_mode = 0; lm_len = 3;
        check_head("never", 1'b1);
        handshake();
        take_rsp("after_never", 1'b0, 0);

        // Reset in the middle of a running job
        lm_len = 10;
        push(XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        n = 0;
        while (loop_busy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_word1", loop_word1, 32'd0);
        exp_q.delete();
        saw = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) saw = 1'b1;
        end
        chk("midrst_no_rsp", {31'd0, saw}, 32'd0);

        // Randomized jobs
        for (int k = 0; k < 12; k++) begin
            lm_len = $urandom_range(1, 5);
            rc = AluCmd'($urandom_range(0, 7));
            push(rc, $urandom, $urandom);
            take_rsp("rand", 1'b0, $urandom_range(0, 3));
        end

        chk("start_pulse_shape", {31'd0, pulse_bad}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
